csb2cacc_arb: RTL and testbench
===============================

Name: csb2cacc_arb

Overview:
- Shares the single csb2cacc request channel between two CSB requesters (r0 = primary CSB master, r1 = debug/secondary master).
- Round-robin arbitration; issues the granted request into the csb2cacc retiming pipe.
- Tracks outstanding response-bearing requests and routes each cacc2csb response back to the requester that issued it, in order.
- Sits between the CSB masters and the csb2cacc retiming pipe, in the nvdla_core_clk domain.

Parameters:
- MAX_OUTSTANDING, 4, maximum in-flight response-bearing requests; power of 2, range 2..16; sets ID FIFO depth.
- CNT_W, 3, outstanding counter width; equals clog2(MAX_OUTSTANDING)+1.

Ports:
- nvdla_core_clk  in  1  core clock; the only clock.
- nvdla_core_rst  in  1  asynchronous reset, active-high.
- r0_req_pvld  in  1  requester 0 request valid.
- r0_req_prdy  out  1  requester 0 request ready.
- r0_req_pd  in  63  requester 0 CSB request packet.
- r0_resp_valid  out  1  requester 0 response valid.
- r0_resp_pd  out  34  requester 0 response packet.
- r1_req_pvld  in  1  requester 1 request valid.
- r1_req_prdy  out  1  requester 1 request ready.
- r1_req_pd  in  63  requester 1 CSB request packet.
- r1_resp_valid  out  1  requester 1 response valid.
- r1_resp_pd  out  34  requester 1 response packet.
- csb2cacc_req_pvld  out  1  request valid into the retiming pipe.
- csb2cacc_req_prdy  in  1  retiming pipe ready.
- csb2cacc_req_pd  out  63  issued request packet.
- cacc2csb_resp_valid  in  1  response valid from the retiming pipe; no backpressure.
- cacc2csb_resp_pd  in  34  response packet.
- outstanding_cnt  out  CNT_W  current in-flight response-bearing count.
- resp_orphan_err  out  1  sticky flag: a response arrived with nothing outstanding.

Behaviour:
- Reset: all outputs 0, including both resp_valid outputs, both prdy outputs, csb2cacc_req_pvld, outstanding_cnt and resp_orphan_err. ID FIFO empty; round-robin pointer selects r0 first.
- Request packet fields used by this block: bit 54 = write, bit 55 = nposted. The packet is passed through unmodified.
- A request needs a response (NR = 1) when write = 0, or when write = 1 and nposted = 1.
- Output stage: a single register. It may load when it is empty or when csb2cacc_req_prdy = 1 in the same cycle. csb2cacc_req_pvld/pd hold stable until accepted.
- Eligibility: a requester is eligible when its pvld = 1 and either its NR = 0 or outstanding_cnt < MAX_OUTSTANDING.
- Grant: only when the output stage can load. With both requesters eligible, grant the pointer's requester, then move the pointer to the other requester. With one eligible, grant it and leave the pointer unchanged.
- rN_req_prdy = grant to N, combinational. At most one prdy is high per cycle.
- Issue latency: request accepted in cycle T appears on csb2cacc_req_pvld in cycle T+1.
- On a granted NR = 1 request: push the requester ID (0/1) to the ID FIFO and increment outstanding_cnt. The push happens at grant time, not when the pipe accepts.
- Response routing: on cacc2csb_resp_valid with the FIFO non-empty, pop the head ID and register the pd to that requester. rN_resp_valid pulses one cycle at T+1, with rN_resp_pd = cacc2csb_resp_pd.
- Idle response ports: the non-selected requester's resp_valid stays 0. Its resp_pd holds its last value.
- Simultaneous push and pop in the same cycle: FIFO occupancy and outstanding_cnt are unchanged, and the counter never transiently overflows.
- Eligibility is computed from the pre-pop count. A response arriving in the same cycle does not free a credit until the next cycle.
- Orphan response (valid with FIFO empty): drop the response, set resp_orphan_err (sticky until reset), generate no resp_valid and leave the count unchanged.
- Reset mid-operation: all in-flight state is discarded, FIFO and counter clear, and the output-stage request is dropped (pvld returns to 0).

Test Plan:
- Single r0 read (pd bit54=0, addr 0x1234), pipe returns a response 3 cycles later with pd 0x0_DEADBEEF -> csb2cacc_req_pvld at T+1; r0_resp_valid one cycle after the response with pd 0x0_DEADBEEF; outstanding_cnt 1 -> 0; r1_resp_valid stays 0.
- r0 and r1 both hold pvld for 6 cycles, all posted writes -> grants alternate r0, r1, r0, r1, r0, r1; outstanding_cnt stays 0.
- r1 issues 4 reads back-to-back with no responses -> outstanding_cnt = 4; a 5th r1 read stalls (prdy = 0); a posted write from r0 is still granted; after one response the 5th read is granted the next cycle.
- Interleaved reads r0, r1, r0, responses returned with data A, B, C -> r0 gets A, r1 gets B, r0 gets C.
- With count = 4, a response and a new read arrive in the same cycle -> the read is not granted that cycle but is granted the next; count ends at 4.
- cacc2csb_resp_valid with nothing outstanding -> no rN_resp_valid; resp_orphan_err = 1 and stays set until nvdla_core_rst is asserted.
- Assert reset with 2 outstanding and pvld held at the output stage -> all outputs 0 during reset; the first request after reset is granted to r0.

Source files
------------

// File: rtl/csb2cacc_arb.sv
// -----------------------------------------------------------------------------
// csb2cacc_arb
//
// Shares the csb2cacc request channel between two CSB requesters. r0 is the
// primary CSB master and r1 is the debug/secondary master. Arbitration is
// round-robin. The granted request is registered into a single-entry output
// stage that feeds the csb2cacc retiming pipe.
//
// Requests that expect a response are reads, and writes with nposted set. For
// each one the block records the issuing requester in an in-order ID FIFO.
// Each cacc2csb response pops the FIFO head and is steered back to that
// requester.
//
// Ports
//   nvdla_core_clk / nvdla_core_rst : clock, asynchronous active-high reset
//   rN_req_pvld/prdy/pd             : request handshake from requester N
//   rN_resp_valid/pd                : routed response pulse to requester N
//   csb2cacc_req_pvld/prdy/pd       : issued request into the retiming pipe
//   cacc2csb_resp_valid/pd          : response from the pipe (no backpressure)
//   outstanding_cnt                 : in-flight response-bearing requests
//   resp_orphan_err                 : sticky, response seen with none in flight
// -----------------------------------------------------------------------------
module csb2cacc_arb #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rst,
   input  logic             r0_req_pvld,
   output logic             r0_req_prdy,
   input  logic [62:0]      r0_req_pd,
   output logic             r0_resp_valid,
   output logic [33:0]      r0_resp_pd,
   input  logic             r1_req_pvld,
   output logic             r1_req_prdy,
   input  logic [62:0]      r1_req_pd,
   output logic             r1_resp_valid,
   output logic [33:0]      r1_resp_pd,
   output logic             csb2cacc_req_pvld,
   input  logic             csb2cacc_req_prdy,
   output logic [62:0]      csb2cacc_req_pd,
   input  logic             cacc2csb_resp_valid,
   input  logic [33:0]      cacc2csb_resp_pd,
   output logic [CNT_W-1:0] outstanding_cnt,
   output logic             resp_orphan_err
);

   localparam int               PTR_W   = $clog2(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   // Output stage
   logic             out_vld_q, out_vld_d;
   logic [62:0]      out_pd_q, out_pd_d;
   // Round-robin pointer: 0 favours r0, 1 favours r1
   logic             rr_q, rr_d;
   // ID FIFO bookkeeping; the outstanding count doubles as FIFO occupancy
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             id_mem_q [MAX_OUTSTANDING];
   // Response outputs
   logic             r0_rv_q, r0_rv_d;
   logic             r1_rv_q, r1_rv_d;
   logic [33:0]      r0_rpd_q, r0_rpd_d;
   logic [33:0]      r1_rpd_q, r1_rpd_d;
   logic             orphan_q, orphan_d;

   logic             nr0, nr1;
   logic             elig0, elig1;
   logic             can_load;
   logic             gnt0, gnt1;
   logic             push, pop, push_id, head_id;

   // A response is expected for reads, and for writes with nposted set.
   assign nr0 = ~r0_req_pd[54] | r0_req_pd[55];
   assign nr1 = ~r1_req_pd[54] | r1_req_pd[55];

   // Credits are judged on the pre-pop count, so a response arriving this
   // cycle only frees its slot for the following cycle.
   assign elig0 = r0_req_pvld & (~nr0 | (cnt_q < MAX_CNT));
   assign elig1 = r1_req_pvld & (~nr1 | (cnt_q < MAX_CNT));

   assign can_load = ~out_vld_q | csb2cacc_req_prdy;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      rr_d = rr_q;
      if (can_load) begin
         if (elig0 && elig1) begin
            gnt0 = ~rr_q;
            gnt1 = rr_q;
            rr_d = ~rr_q;
         end else begin
            gnt0 = elig0;
            gnt1 = elig1;
         end
      end
   end

   // Ready is held low while reset is asserted so nothing is acknowledged
   // that the (held-in-reset) output stage could not capture.
   assign r0_req_prdy = gnt0 & ~nvdla_core_rst;
   assign r1_req_prdy = gnt1 & ~nvdla_core_rst;

   assign push    = (gnt0 & nr0) | (gnt1 & nr1);
   assign push_id = gnt1;
   assign head_id = id_mem_q[rd_ptr_q];
   assign pop     = cacc2csb_resp_valid & (cnt_q != '0);

   always_comb begin
      out_vld_d = out_vld_q;
      out_pd_d  = out_pd_q;
      if (gnt0) begin
         out_vld_d = 1'b1;
         out_pd_d  = r0_req_pd;
      end else if (gnt1) begin
         out_vld_d = 1'b1;
         out_pd_d  = r1_req_pd;
      end else if (csb2cacc_req_prdy) begin
         out_vld_d = 1'b0;
      end
   end

   // Push and pop together leave the count alone, so it never steps past
   // MAX_OUTSTANDING even for a cycle.
   always_comb begin
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // The idle requester's pd keeps its last routed value.
   always_comb begin
      r0_rv_d  = pop & ~head_id;
      r1_rv_d  = pop & head_id;
      r0_rpd_d = r0_rpd_q;
      r1_rpd_d = r1_rpd_q;
      if (pop && !head_id) begin
         r0_rpd_d = cacc2csb_resp_pd;
      end
      if (pop && head_id) begin
         r1_rpd_d = cacc2csb_resp_pd;
      end
      orphan_d = orphan_q | (cacc2csb_resp_valid & (cnt_q == '0));
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         out_vld_q <= 1'b0;
         out_pd_q  <= '0;
         rr_q      <= 1'b0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         r0_rv_q   <= 1'b0;
         r1_rv_q   <= 1'b0;
         r0_rpd_q  <= '0;
         r1_rpd_q  <= '0;
         orphan_q  <= 1'b0;
      end else begin
         out_vld_q <= out_vld_d;
         out_pd_q  <= out_pd_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         r0_rv_q   <= r0_rv_d;
         r1_rv_q   <= r1_rv_d;
         r0_rpd_q  <= r0_rpd_d;
         r1_rpd_q  <= r1_rpd_d;
         orphan_q  <= orphan_d;
      end
   end

   // FIFO storage needs no reset: entries are only read while occupied.
   always_ff @(posedge nvdla_core_clk) begin
      if (push) begin
         id_mem_q[wr_ptr_q] <= push_id;
      end
   end

   assign csb2cacc_req_pvld = out_vld_q;
   assign csb2cacc_req_pd   = out_pd_q;
   assign outstanding_cnt   = cnt_q;
   assign r0_resp_valid     = r0_rv_q;
   assign r1_resp_valid     = r1_rv_q;
   assign r0_resp_pd        = r0_rpd_q;
   assign r1_resp_pd        = r1_rpd_q;
   assign resp_orphan_err   = orphan_q;

endmodule

// File: tb/tb_csb2cacc_arb.sv
// -----------------------------------------------------------------------------
// tb_csb2cacc_arb
//
// Self-checking bench for csb2cacc_arb. A cycle-by-cycle vector table covers
// round-robin alternation, credit exhaustion, same-cycle response/request,
// output-stage backpressure, drain and an orphan response. Hand-written
// sequences cover a single read round trip, in-order response routing and
// reset in the middle of traffic.
// -----------------------------------------------------------------------------
module tb_csb2cacc_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_pvld, r1_pvld;
   logic [62:0] r0_pd, r1_pd;
   logic        r0_prdy, r1_prdy;
   logic        r0_rv, r1_rv;
   logic [33:0] r0_rpd, r1_rpd;
   logic        out_pvld;
   logic        pipe_rdy;
   logic [62:0] out_pd;
   logic        resp_vld;
   logic [33:0] resp_pd;
   logic [2:0]  cnt;
   logic        orphan;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   csb2cacc_arb #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
      .nvdla_core_clk      (clk),
      .nvdla_core_rst      (rst),
      .r0_req_pvld         (r0_pvld),
      .r0_req_prdy         (r0_prdy),
      .r0_req_pd           (r0_pd),
      .r0_resp_valid       (r0_rv),
      .r0_resp_pd          (r0_rpd),
      .r1_req_pvld         (r1_pvld),
      .r1_req_prdy         (r1_prdy),
      .r1_req_pd           (r1_pd),
      .r1_resp_valid       (r1_rv),
      .r1_resp_pd          (r1_rpd),
      .csb2cacc_req_pvld   (out_pvld),
      .csb2cacc_req_prdy   (pipe_rdy),
      .csb2cacc_req_pd     (out_pd),
      .cacc2csb_resp_valid (resp_vld),
      .cacc2csb_resp_pd    (resp_pd),
      .outstanding_cnt     (cnt),
      .resp_orphan_err     (orphan)
   );

   typedef struct {
      logic        p0;
      logic [62:0] pd0;
      logic        p1;
      logic [62:0] pd1;
      logic        rdy;
      logic        rv;
      logic [33:0] rpd;
      logic        e_prdy0;
      logic        e_prdy1;
      logic        e_pvld;
      logic [62:0] e_pd;
      logic [2:0]  e_cnt;
      logic        e_rv0;
      logic        e_rv1;
      logic [33:0] e_rpd;
      logic        e_orphan;
   } vec_t;

   vec_t vecs[21];

   function automatic logic [62:0] mk(input logic wr, input logic np, input logic [53:0] addr);
      return {7'h15, np, wr, addr};
   endfunction

   function automatic vec_t row(
      input logic p0, input logic [62:0] pd0, input logic p1, input logic [62:0] pd1,
      input logic rdy, input logic rv, input logic [33:0] rpd,
      input logic e0, input logic e1, input logic epv, input logic [62:0] epd,
      input logic [2:0] ecnt, input logic erv0, input logic erv1, input logic [33:0] erpd,
      input logic eorph);
      vec_t v;
      v.p0 = p0; v.pd0 = pd0; v.p1 = p1; v.pd1 = pd1;
      v.rdy = rdy; v.rv = rv; v.rpd = rpd;
      v.e_prdy0 = e0; v.e_prdy1 = e1; v.e_pvld = epv; v.e_pd = epd;
      v.e_cnt = ecnt; v.e_rv0 = erv0; v.e_rv1 = erv1; v.e_rpd = erpd;
      v.e_orphan = eorph;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic p0, input logic [62:0] d0, input logic p1,
                        input logic [62:0] d1, input logic rdy, input logic rv,
                        input logic [33:0] rpd);
      r0_pvld  = p0;
      r0_pd    = d0;
      r1_pvld  = p1;
      r1_pd    = d1;
      pipe_rdy = rdy;
      resp_vld = rv;
      resp_pd  = rpd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_prdy0"}, 64'(r0_prdy), 64'd0);
      check({tag, "_prdy1"}, 64'(r1_prdy), 64'd0);
      check({tag, "_pvld"},  64'(out_pvld), 64'd0);
      check({tag, "_cnt"},   64'(cnt), 64'd0);
      check({tag, "_rv0"},   64'(r0_rv), 64'd0);
      check({tag, "_rv1"},   64'(r1_rv), 64'd0);
      check({tag, "_orph"},  64'(orphan), 64'd0);
   endtask

   logic [62:0] W0, W1, R1, RD0, R0A, R1A, R0B;
   logic [62:0] Z;

   initial begin
      W0  = mk(1'b1, 1'b0, 54'h100);
      W1  = mk(1'b1, 1'b0, 54'h200);
      R1  = mk(1'b0, 1'b0, 54'h300);
      RD0 = mk(1'b0, 1'b0, 54'h1234);
      R0A = mk(1'b0, 1'b0, 54'h400);
      R1A = mk(1'b0, 1'b0, 54'h500);
      R0B = mk(1'b1, 1'b1, 54'h600);
      Z   = '0;

      // p0 pd0 p1 pd1 rdy rv rpd | prdy0 prdy1 pvld pd cnt rv0 rv1 rpd orphan
      vecs[0]  = row(1, W0, 1, W1, 1, 0, 34'h0,          1, 0, 1, W0, 3'd0, 0, 0, 34'h0, 0);
      vecs[1]  = row(1, W0, 1, W1, 1, 0, 34'h0,          0, 1, 1, W1, 3'd0, 0, 0, 34'h0, 0);
      vecs[2]  = row(1, W0, 1, W1, 1, 0, 34'h0,          1, 0, 1, W0, 3'd0, 0, 0, 34'h0, 0);
      vecs[3]  = row(1, W0, 1, W1, 1, 0, 34'h0,          0, 1, 1, W1, 3'd0, 0, 0, 34'h0, 0);
      vecs[4]  = row(1, W0, 1, W1, 1, 0, 34'h0,          1, 0, 1, W0, 3'd0, 0, 0, 34'h0, 0);
      vecs[5]  = row(1, W0, 1, W1, 1, 0, 34'h0,          0, 1, 1, W1, 3'd0, 0, 0, 34'h0, 0);
      vecs[6]  = row(0, Z,  0, Z,  1, 0, 34'h0,          0, 0, 0, Z,  3'd0, 0, 0, 34'h0, 0);
      vecs[7]  = row(0, Z,  1, R1, 1, 0, 34'h0,          0, 1, 1, R1, 3'd1, 0, 0, 34'h0, 0);
      vecs[8]  = row(0, Z,  1, R1, 1, 0, 34'h0,          0, 1, 1, R1, 3'd2, 0, 0, 34'h0, 0);
      vecs[9]  = row(0, Z,  1, R1, 1, 0, 34'h0,          0, 1, 1, R1, 3'd3, 0, 0, 34'h0, 0);
      vecs[10] = row(0, Z,  1, R1, 1, 0, 34'h0,          0, 1, 1, R1, 3'd4, 0, 0, 34'h0, 0);
      vecs[11] = row(1, W0, 1, R1, 1, 0, 34'h0,          1, 0, 1, W0, 3'd4, 0, 0, 34'h0, 0);
      vecs[12] = row(0, Z,  1, R1, 1, 1, 34'h1_0000_0013, 0, 0, 0, Z,  3'd3, 0, 1, 34'h1_0000_0013, 0);
      vecs[13] = row(0, Z,  1, R1, 1, 0, 34'h0,          0, 1, 1, R1, 3'd4, 0, 0, 34'h0, 0);
      vecs[14] = row(1, W0, 0, Z,  0, 0, 34'h0,          0, 0, 1, R1, 3'd4, 0, 0, 34'h0, 0);
      vecs[15] = row(1, W0, 0, Z,  1, 0, 34'h0,          1, 0, 1, W0, 3'd4, 0, 0, 34'h0, 0);
      vecs[16] = row(0, Z,  0, Z,  1, 1, 34'h2_0000_0017, 0, 0, 0, Z,  3'd3, 0, 1, 34'h2_0000_0017, 0);
      vecs[17] = row(0, Z,  0, Z,  1, 1, 34'h2_0000_0018, 0, 0, 0, Z,  3'd2, 0, 1, 34'h2_0000_0018, 0);
      vecs[18] = row(0, Z,  0, Z,  1, 1, 34'h2_0000_0019, 0, 0, 0, Z,  3'd1, 0, 1, 34'h2_0000_0019, 0);
      vecs[19] = row(0, Z,  0, Z,  1, 1, 34'h2_0000_0020, 0, 0, 0, Z,  3'd0, 0, 1, 34'h2_0000_0020, 0);
      vecs[20] = row(0, Z,  0, Z,  1, 1, 34'h3_0BAD_0BAD, 0, 0, 0, Z,  3'd0, 0, 0, 34'h0, 1);

      // ---------------- reset state ----------------
      rst = 1'b1;
      drive(0, Z, 0, Z, 1'b0, 1'b0, 34'h0);
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;

      // ---------------- single r0 read round trip ----------------
      drive(1, RD0, 0, Z, 1'b1, 1'b0, 34'h0);
      #1;
      check("rd_prdy0", 64'(r0_prdy), 64'd1);
      check("rd_prdy1", 64'(r1_prdy), 64'd0);
      tick();
      check("rd_pvld", 64'(out_pvld), 64'd1);
      check("rd_pd", 64'(out_pd), 64'(RD0));
      check("rd_cnt1", 64'(cnt), 64'd1);
      drive(0, Z, 0, Z, 1'b1, 1'b0, 34'h0);
      tick();
      check("rd_pvld_drop", 64'(out_pvld), 64'd0);
      tick();
      tick();
      drive(0, Z, 0, Z, 1'b1, 1'b1, 34'h0_DEAD_BEEF);
      tick();
      check("rd_rv0", 64'(r0_rv), 64'd1);
      check("rd_rpd0", 64'(r0_rpd), 64'h0_DEAD_BEEF);
      check("rd_rv1", 64'(r1_rv), 64'd0);
      check("rd_cnt0", 64'(cnt), 64'd0);
      drive(0, Z, 0, Z, 1'b1, 1'b0, 34'h0);
      tick();
      check("rd_rv0_pulse", 64'(r0_rv), 64'd0);

      // ---------------- vector table ----------------
      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].p0, vecs[i].pd0, vecs[i].p1, vecs[i].pd1,
               vecs[i].rdy, vecs[i].rv, vecs[i].rpd);
         #1;
         check($sformatf("v%0d_prdy0", i), 64'(r0_prdy), 64'(vecs[i].e_prdy0));
         check($sformatf("v%0d_prdy1", i), 64'(r1_prdy), 64'(vecs[i].e_prdy1));
         tick();
         check($sformatf("v%0d_pvld", i), 64'(out_pvld), 64'(vecs[i].e_pvld));
         if (vecs[i].e_pvld)
            check($sformatf("v%0d_pd", i), 64'(out_pd), 64'(vecs[i].e_pd));
         check($sformatf("v%0d_cnt", i), 64'(cnt), 64'(vecs[i].e_cnt));
         check($sformatf("v%0d_rv0", i), 64'(r0_rv), 64'(vecs[i].e_rv0));
         check($sformatf("v%0d_rv1", i), 64'(r1_rv), 64'(vecs[i].e_rv1));
         if (vecs[i].e_rv0)
            check($sformatf("v%0d_rpd0", i), 64'(r0_rpd), 64'(vecs[i].e_rpd));
         if (vecs[i].e_rv1)
            check($sformatf("v%0d_rpd1", i), 64'(r1_rpd), 64'(vecs[i].e_rpd));
         check($sformatf("v%0d_orph", i), 64'(orphan), 64'(vecs[i].e_orphan));
      end

      // ---------------- interleaved routing r0, r1, r0 ----------------
      drive(1, R0A, 0, Z, 1'b1, 1'b0, 34'h0);
      tick();
      drive(0, Z, 1, R1A, 1'b1, 1'b0, 34'h0);
      tick();
      drive(1, R0B, 0, Z, 1'b1, 1'b0, 34'h0);
      tick();
      check("il_cnt3", 64'(cnt), 64'd3);
      drive(0, Z, 0, Z, 1'b1, 1'b1, 34'h0_AAAA_000A);
      tick();
      check("il_a_rv0", 64'(r0_rv), 64'd1);
      check("il_a_rv1", 64'(r1_rv), 64'd0);
      check("il_a_pd", 64'(r0_rpd), 64'h0_AAAA_000A);
      drive(0, Z, 0, Z, 1'b1, 1'b1, 34'h1_BBBB_000B);
      tick();
      check("il_b_rv0", 64'(r0_rv), 64'd0);
      check("il_b_rv1", 64'(r1_rv), 64'd1);
      check("il_b_pd", 64'(r1_rpd), 64'h1_BBBB_000B);
      check("il_b_hold0", 64'(r0_rpd), 64'h0_AAAA_000A);
      drive(0, Z, 0, Z, 1'b1, 1'b1, 34'h2_CCCC_000C);
      tick();
      check("il_c_rv0", 64'(r0_rv), 64'd1);
      check("il_c_rv1", 64'(r1_rv), 64'd0);
      check("il_c_pd", 64'(r0_rpd), 64'h2_CCCC_000C);
      check("il_cnt0", 64'(cnt), 64'd0);
      check("il_orph_sticky", 64'(orphan), 64'd1);

      // ---------------- reset mid-operation ----------------
      drive(1, R0A, 1, R1A, 1'b1, 1'b0, 34'h0);
      #1;
      check("mr_gnt_r0", 64'(r0_prdy), 64'd1);
      tick();
      drive(0, Z, 1, R1A, 1'b1, 1'b0, 34'h0);
      tick();
      check("mr_cnt2", 64'(cnt), 64'd2);
      drive(1, R0A, 1, R1A, 1'b0, 1'b0, 34'h0);
      tick();
      check("mr_pvld_held", 64'(out_pvld), 64'd1);
      check("mr_pd_held", 64'(out_pd), 64'(R1A));
      rst = 1'b1;
      #1;
      check_all_zero("mr_rst");
      tick();
      check_all_zero("mr_rst2");
      rst = 1'b0;
      drive(1, R0A, 1, R1A, 1'b1, 1'b0, 34'h0);
      #1;
      check("mr_post_prdy0", 64'(r0_prdy), 64'd1);
      check("mr_post_prdy1", 64'(r1_prdy), 64'd0);
      tick();
      check("mr_post_pd", 64'(out_pd), 64'(R0A));
      check("mr_post_cnt", 64'(cnt), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
